fp_addsub_seq: RTL

//  Parametrised, multi-cycle IEEE-754-style floating-point add/subtract unit; successor to the

---
 rtl/fp_addsub_seq.sv | 226 ++++++++++++++++++++++
 1 files changed

// File: rtl/fp_addsub_seq.sv
// Multi-cycle floating-point add/subtract with round-to-nearest-even, special-value bypass and
// exception flags. One operation in flight; start/done handshake with a fixed five-cycle latency.
module fp_addsub_seq #(
  parameter int EXP_W = 11,
  parameter int MAN_W = 52
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   op_sub,
  input  logic [EXP_W+MAN_W:0]   a,
  input  logic [EXP_W+MAN_W:0]   b,
  output logic                   busy,
  output logic                   done,
  output logic [EXP_W+MAN_W:0]   result,
  output logic [3:0]             flags
);

  localparam int W    = 1 + EXP_W + MAN_W;
  localparam int M    = MAN_W + 1;          // mantissa with hidden bit
  localparam int X    = MAN_W + 4;          // mantissa plus guard, round, sticky
  localparam int EE   = EXP_W + 2;          // working exponent with sign bit
  localparam int LZ_W = $clog2(X + 1);

  localparam logic [EXP_W-1:0] EXP_MAX   = '1;
  localparam logic [EXP_W-1:0] SHIFT_LIM = EXP_W'(MAN_W + 3);
  localparam logic [W-1:0]     QNAN      = {1'b0, {EXP_W{1'b1}}, 1'b1, {(MAN_W-1){1'b0}}};

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_UNPACK = 3'd1;
  localparam logic [2:0] S_ALIGN  = 3'd2;
  localparam logic [2:0] S_ADD    = 3'd3;
  localparam logic [2:0] S_NORM   = 3'd4;
  localparam logic [2:0] S_ROUND  = 3'd5;

  logic [2:0]       state;
  logic [W-1:0]     a_q, b_q;
  logic             sa_u, sb_u, za_u, zb_u, ia_u, ib_u, na_u, nb_u;
  logic [EXP_W-1:0] ea_u, eb_u;
  logic [M-1:0]     ma_u, mb_u;
  logic             sign_r, sub_r, spec_r;
  logic [EXP_W-1:0] exp_r;
  logic [X-1:0]     big_r, small_r;
  logic [W-1:0]     spec_res_r;
  logic [3:0]       spec_flg_r;
  logic [X:0]       sum_r;

  assign busy = (state != S_IDLE);
  assign done = (state == S_ROUND);

  // ---------------- control and architectural outputs ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= S_IDLE;
      result <= '0;
      flags  <= '0;
    end else begin
      case (state)
        S_IDLE:   if (start) state <= S_UNPACK;
        S_UNPACK: state <= S_ALIGN;
        S_ALIGN:  state <= S_ADD;
        S_ADD:    state <= S_NORM;
        S_NORM: begin
          state  <= S_ROUND;
          result <= res_n;
          flags  <= flg_n;
        end
        S_ROUND:  state <= S_IDLE;
        default:  state <= S_IDLE;
      endcase
    end
  end

  // ---------------- ALIGN: order by magnitude, shift the smaller operand ----------------
  logic             a_big, sign_al;
  logic [EXP_W-1:0] big_e, diff;
  logic [M-1:0]     big_m, small_m;
  logic [X-1:0]     small_ext, shifted;

  // NOTE: every combinational output gets a default first so no latch is inferred.
  always_comb begin
    a_big     = (ea_u > eb_u) || ((ea_u == eb_u) && (ma_u >= mb_u));
    big_e     = a_big ? ea_u : eb_u;
    diff      = a_big ? (ea_u - eb_u) : (eb_u - ea_u);
    big_m     = a_big ? ma_u : mb_u;
    small_m   = a_big ? mb_u : ma_u;
    sign_al   = a_big ? sa_u : sb_u;
    small_ext = {small_m, 3'b000};
    shifted   = '0;
    if (diff >= SHIFT_LIM) begin
      shifted[0] = |small_m;
    end else begin
      shifted    = small_ext >> diff;
      shifted[0] = shifted[0] | (|(small_ext & ~({X{1'b1}} << diff)));
    end
  end

  logic         spec_al;
  logic [W-1:0] spec_res_al;
  logic [3:0]   spec_flg_al;

  always_comb begin
    spec_al     = 1'b1;
    spec_res_al = '0;
    spec_flg_al = '0;
    if (na_u || nb_u) begin
      spec_res_al = QNAN;
    end else if (ia_u && ib_u && (sa_u != sb_u)) begin
      spec_res_al = QNAN;
      spec_flg_al = 4'b1000;
    end else if (ia_u) begin
      spec_res_al = {sa_u, EXP_MAX, {MAN_W{1'b0}}};
    end else if (ib_u) begin
      spec_res_al = {sb_u, EXP_MAX, {MAN_W{1'b0}}};
    end else if (za_u && zb_u) begin
      // Opposite-signed zeros sum to +0; only two negative zeros keep the sign.
      spec_res_al = {sa_u & sb_u, {(W-1){1'b0}}};
    end else if (za_u) begin
      spec_res_al = {sb_u, eb_u, mb_u[MAN_W-1:0]};
    end else if (zb_u) begin
      spec_res_al = {sa_u, ea_u, ma_u[MAN_W-1:0]};
    end else begin
      spec_al = 1'b0;
    end
  end

  // ---------------- ADD: magnitude add or larger-minus-smaller ----------------
  logic [X:0] sum_n;

  always_comb begin
    sum_n = sub_r ? ({1'b0, big_r} - {1'b0, small_r})
                  : ({1'b0, big_r} + {1'b0, small_r});
  end

  // ---------------- NORM + ROUND ----------------
  logic [LZ_W-1:0]  lzc;
  logic             found, inc;
  logic [X-1:0]     n_m;
  logic [EE-1:0]    e_n, e_o;
  logic [M:0]       mr;
  logic [MAN_W-1:0] frac_o;
  logic [W-1:0]     res_n;
  logic [3:0]       flg_n;

  always_comb begin
    lzc   = '0;
    found = 1'b0;
    for (int i = X - 1; i >= 0; i--) begin
      if (!found) begin
        if (sum_r[i]) found = 1'b1;
        else          lzc   = lzc + LZ_W'(1);
      end
    end

    if (sum_r[X]) begin
      n_m = {sum_r[X:2], sum_r[1] | sum_r[0]};
      e_n = EE'(exp_r) + EE'(1);
    end else begin
      n_m = sum_r[X-1:0] << lzc;
      e_n = EE'(exp_r) - EE'(lzc);
    end

    inc = n_m[2] & (n_m[1] | n_m[0] | n_m[3]);
    mr  = {1'b0, n_m[X-1:3]} + (M+1)'(inc);
    if (mr[M]) begin
      frac_o = mr[MAN_W:1];
      e_o    = e_n + EE'(1);
    end else begin
      frac_o = mr[MAN_W-1:0];
      e_o    = e_n;
    end

    res_n = {sign_r, e_o[EXP_W-1:0], frac_o};
    flg_n = {3'b000, n_m[2] | n_m[1] | n_m[0]};
    if (spec_r) begin
      res_n = spec_res_r;
      flg_n = spec_flg_r;
    end else if (sum_r == '0) begin
      res_n = '0;
      flg_n = '0;
    end else if (!e_o[EE-1] && (e_o >= EE'(EXP_MAX))) begin
      res_n = {sign_r, EXP_MAX, {MAN_W{1'b0}}};
      flg_n = 4'b0101;
    end else if (e_o[EE-1] || (e_o == '0)) begin
      res_n = {sign_r, {(W-1){1'b0}}};
      flg_n = 4'b0011;
    end
  end

  // ---------------- datapath registers ----------------
  // NOTE: datapath registers carry no reset; each is written before the stage that reads it.
  always_ff @(posedge clk) begin
    if (state == S_IDLE && start) begin
      a_q <= a;
      b_q <= {b[W-1] ^ op_sub, b[W-2:0]};
    end
    if (state == S_UNPACK) begin
      sa_u <= a_q[W-1];
      sb_u <= b_q[W-1];
      ea_u <= a_q[W-2:MAN_W];
      eb_u <= b_q[W-2:MAN_W];
      ma_u <= {|a_q[W-2:MAN_W], a_q[MAN_W-1:0]};
      mb_u <= {|b_q[W-2:MAN_W], b_q[MAN_W-1:0]};
      za_u <= (a_q[W-2:MAN_W] == '0);
      zb_u <= (b_q[W-2:MAN_W] == '0);
      ia_u <= (a_q[W-2:MAN_W] == EXP_MAX) && (a_q[MAN_W-1:0] == '0);
      ib_u <= (b_q[W-2:MAN_W] == EXP_MAX) && (b_q[MAN_W-1:0] == '0);
      na_u <= (a_q[W-2:MAN_W] == EXP_MAX) && (a_q[MAN_W-1:0] != '0);
      nb_u <= (b_q[W-2:MAN_W] == EXP_MAX) && (b_q[MAN_W-1:0] != '0);
    end
    if (state == S_ALIGN) begin
      sign_r     <= sign_al;
      exp_r      <= big_e;
      big_r      <= {big_m, 3'b000};
      small_r    <= shifted;
      sub_r      <= sa_u ^ sb_u;
      spec_r     <= spec_al;
      spec_res_r <= spec_res_al;
      spec_flg_r <= spec_flg_al;
    end
    if (state == S_ADD) begin
      sum_r <= sum_n;
    end
  end

endmodule
